// File: rtl/sfifo_pkg.sv
// Shared stream-FIFO definitions: default widths/depths, the stream word type
// and saturating counter helpers used by the FIFO and its drain logic.
package sfifo_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int BUF_DEPTH_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] stream_word_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/drain_buf.sv
// Circular output buffer for fifo_drain: head/tail pointers with wrap at
// DEPTH-1 and an occupancy count one bit wider than the pointers.
module drain_buf
  import sfifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = ptr_next(tail_q);
    end
    if (pop) begin
      head_d = ptr_next(head_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Clearing the storage keeps the head word (and so m_data) at zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/fifo_drain.sv
// Drains a fixed-latency FIFO read port into a valid/ready stream through a
// small circular buffer. Optional statistics under FIFO_DRAIN_STATS_EN.
module fifo_drain
  import sfifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_udfl,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0]       word_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic             p1_q, p1_d;
  logic             p2_q, p2_d;
  logic             buf_full;
  logic             buf_empty;
  logic             xfer;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0]   committed;

  // Slots already spoken for: stored words plus pops whose data is still on its way.
  always_comb begin
    committed = (CNT_W + 1)'(occ) + (CNT_W + 1)'(p1_q) + (CNT_W + 1)'(p2_q);
    fifo_rd   = ~rst & ~fifo_empty & (committed < (CNT_W + 1)'(BUF_DEPTH));
    p1_d      = fifo_rd;
    p2_d      = p1_q & ~fifo_udfl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q <= 1'b0;
      p2_q <= 1'b0;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
    end
  end

  assign m_valid = ~buf_empty;
  assign xfer    = m_valid & m_ready;

  drain_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (p2_q),
    .push_data (fifo_dout),
    .pop       (xfer),
    .full      (buf_full),
    .empty     (buf_empty),
    .head_data (m_data),
    .count     (occ)
  );

  // Arriving data must always find a free slot unless the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(p2_q && buf_full && !xfer));
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (xfer) begin
      word_cnt_d = sat_inc32(word_cnt_q);
    end
    if (p1_q && fifo_udfl) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  // Statistics disabled: no counter state is built.
`endif

endmodule
